regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a per-register pending-write scoreboard. It is the successor to the single-write, dual-read register file.
- Serves NUM_RD combinational read ports and NUM_WR write-back ports.
- Optionally forwards same-cycle write data to readers.
- Tracks registers reserved by in-flight producers (loads, multi-cycle ops) so decode can stall.
- Sits between the decode and write-back stages of the rv32imc core.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
(local) AW = $clog2(NUM_REGS)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active high
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses, port p at [p*AW +: AW]
wr_data  in  NUM_WR*XLEN  write data, port p at [p*XLEN +: XLEN]
rsv_en  in  1  reserve (mark pending) request
rsv_addr  in  AW  register to reserve
rd_addr  in  NUM_RD*AW  read addresses
rd_data  out  NUM_RD*XLEN  read data (combinational)
rd_busy  out  NUM_RD  addressed register has an outstanding producer
busy_vec  out  NUM_REGS  full scoreboard, registered

Behaviour:
Reset
- Reset is synchronous: on a posedge clk with rst=1, all registers clear to 0 and busy_vec clears to 0.
- Writes and reservations in that cycle are discarded.
- While rst=1, rd_data=0 and rd_busy=0 regardless of inputs; bypass is suppressed.
- A reset arriving mid-operation drops all pending reservations; there is no recovery state.

Write
- On posedge with wr_en[p]=1, reg[wr_addr[p]] <= wr_data[p].
- If ZERO_REG=1 and wr_addr[p]=0, the write is ignored.
- Write-write collision (same address on two enabled ports): the highest-index port wins. No error is flagged.
- Write latency is 1 cycle (visible from the stored array on the next cycle).

Read
- rd_data[r] = stored reg[rd_addr[r]], purely combinational.
- ZERO_REG=1 and addr 0 -> 0, overriding bypass.
- BYPASS=1: if any enabled write port matches rd_addr[r] (and the address is non-zero when ZERO_REG=1), rd_data[r] = wr_data of the highest-index matching port.
- BYPASS=0: the old value is returned in the write cycle.

Scoreboard (busy_vec, one flop per register)
- rsv_en=1: busy[rsv_addr] <= 1 next cycle. Ignored for addr 0 when ZERO_REG=1.
- Any enabled write to address a: busy[a] <= 0 next cycle.
- Reserve and write to the same address in the same cycle: reserve wins, busy stays/goes 1 (a new producer supersedes the retiring one).
- Reserving an already-busy register: stays 1. There is no counting; a single producer per register is guaranteed by issue logic.
- A write to a non-busy register is legal: data updates and busy stays 0.
- rd_busy[r] = busy[rd_addr[r]] & ~(BYPASS & matching enabled write this cycle).
- Register 0 with ZERO_REG=1 always reports rd_busy=0.
- busy_vec is driven directly from flops (no combinational path from inputs).

Arithmetic/width
- No arithmetic; addresses compare at full AW bits. Unused encodings do not exist because NUM_REGS is a power of two.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEFAULT=32
  - REG_ZERO='0
  - typedef reg_addr_t (logic [4:0]), reg_data_t (logic [XLEN_DEFAULT-1:0])
  - function onehot_priority_hi (highest-index match select), shared by write resolution and bypass.
- Sub-module regfile_scoreboard holds busy flops, reserve/clear priority and rd_busy masking. Parameters: NUM_REGS, NUM_RD, NUM_WR, ZERO_REG, BYPASS.
- Top level holds the data array, write resolution and read/bypass muxes.

Test Plan:
- Reset then write: rst 1 cycle; wr_en[0]=1, addr 5, data 0xDEADBEEF; next cycle rd_addr[0]=5 -> rd_data 0xDEADBEEF; in the write cycle with BYPASS=1 -> 0xDEADBEEF, with BYPASS=0 -> 0.
- Zero register: write 0x12345678 to addr 0 and reserve addr 0 -> rd_data 0, rd_busy 0, busy_vec[0]=0 on all following cycles.
- Write collision (NUM_WR=2): port0 writes 0x1 and port1 writes 0x2 to addr 7 in the same cycle -> same-cycle bypass returns 0x2; stored value next cycle is 0x2.
- Scoreboard lifecycle: reserve addr 10 -> busy_vec[10]=1 next cycle, rd_busy=1. Write addr 10 with 0xAA -> rd_busy=0 in the write cycle (BYPASS=1) with rd_data 0xAA; busy_vec[10]=0 next cycle.
- Simultaneous reserve and write to addr 3 while busy -> busy_vec[3] remains 1; the data is updated.
- Reset mid-flight: registers 4 and 9 reserved and holding 0x55; assert rst together with wr_en to addr 4 -> next cycle busy_vec=0, reg4=0, reg9=0, the write is discarded.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned MAX_WR       = 4;

   typedef logic [4:0]              reg_addr_t;
   typedef logic [XLEN_DEFAULT-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = '0;

   // Keep only the highest-index set bit; later write ports take priority.
   function automatic logic [MAX_WR-1:0] onehot_priority_hi(input logic [MAX_WR-1:0] req);
      logic [MAX_WR-1:0] sel;
      sel = '0;
      for (int i = 0; i < int'(MAX_WR); i++) begin
         if (req[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flop per register, set by reserve, cleared by write-back.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 1,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [NUM_WR*AW-1:0] wr_addr,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_addr,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD-1:0]    rd_busy,
   output logic [NUM_REGS-1:0]  busy_vec
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   // Next scoreboard: retiring writes clear, a new reservation overrides the clear.
   always_comb begin
      busy_nxt = busy;
      for (int p = 0; p < int'(NUM_WR); p++) begin
         if (wr_en[p]) busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
      end
      if (rsv_en && !(ZERO_REG && rsv_addr == AW'(REG_ZERO))) busy_nxt[rsv_addr] = 1'b1;
   end

   // Busy flops with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // Per-port busy, masked when the producer retires this very cycle and data is forwarded.
   always_comb begin
      logic [AW-1:0] addr;
      logic          hit;
      rd_busy = '0;
      addr    = '0;
      hit     = 1'b0;
      for (int r = 0; r < int'(NUM_RD); r++) begin
         addr = rd_addr[r*AW +: AW];
         hit  = 1'b0;
         for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] == addr) hit = 1'b1;
         end
         rd_busy[r] = !rst && busy[addr] && !(BYPASS && hit) &&
                      !(ZERO_REG && addr == AW'(REG_ZERO));
      end
   end

   assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-back forwarding and pending-write scoreboard.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 1,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_WR-1:0]      wr_en,
   input  logic [NUM_WR*AW-1:0]   wr_addr,
   input  logic [NUM_WR*XLEN-1:0] wr_data,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   output logic [NUM_REGS-1:0]    busy_vec
);

   logic [XLEN-1:0]     regs   [NUM_REGS];
   logic [XLEN-1:0]     wr_val [NUM_REGS];
   logic [NUM_REGS-1:0] wr_hit;
   logic [NUM_WR-1:0]   wr_eff;

   // Enabled write ports whose address equals a.
   function automatic logic [NUM_WR-1:0] wr_match(input logic [AW-1:0] a,
                                                  input logic [NUM_WR-1:0] en,
                                                  input logic [NUM_WR*AW-1:0] addrs);
      logic [NUM_WR-1:0] m;
      m = '0;
      for (int p = 0; p < int'(NUM_WR); p++) m[p] = en[p] && addrs[p*AW +: AW] == a;
      return m;
   endfunction

   // Data of the highest-index matching port.
   function automatic logic [XLEN-1:0] pick_wr_data(input logic [NUM_WR-1:0] hit,
                                                    input logic [NUM_WR*XLEN-1:0] data);
      logic [MAX_WR-1:0] sel;
      logic [XLEN-1:0]   res;
      sel = onehot_priority_hi(MAX_WR'(hit));
      res = '0;
      for (int p = 0; p < int'(NUM_WR); p++) begin
         if (sel[p]) res = data[p*XLEN +: XLEN];
      end
      return res;
   endfunction

   // Effective write enables: writes to the hardwired zero register are dropped.
   always_comb begin
      wr_eff = '0;
      for (int p = 0; p < int'(NUM_WR); p++) begin
         wr_eff[p] = wr_en[p] && !(ZERO_REG && wr_addr[p*AW +: AW] == AW'(REG_ZERO));
      end
   end

   // Per-register write resolution with highest-port priority.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         wr_hit[i] = |wr_match(AW'(i), wr_eff, wr_addr);
         wr_val[i] = pick_wr_data(wr_match(AW'(i), wr_eff, wr_addr), wr_data);
      end
   end

   // Storage array with synchronous clear; writes in the reset cycle are discarded.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (rst)            regs[i] <= '0;
         else if (wr_hit[i]) regs[i] <= wr_val[i];
      end
   end

   // Read muxes: zero register first, then forwarded write data, then stored value.
   always_comb begin
      logic [AW-1:0]     addr;
      logic [NUM_WR-1:0] hit;
      rd_data = '0;
      addr    = '0;
      hit     = '0;
      for (int r = 0; r < int'(NUM_RD); r++) begin
         addr = rd_addr[r*AW +: AW];
         hit  = wr_match(addr, wr_eff, wr_addr);
         if (rst || (ZERO_REG && addr == AW'(REG_ZERO)))
            rd_data[r*XLEN +: XLEN] = '0;
         else if (BYPASS && |hit)
            rd_data[r*XLEN +: XLEN] = pick_wr_data(hit, wr_data);
         else
            rd_data[r*XLEN +: XLEN] = regs[addr];
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy),
      .busy_vec (busy_vec)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypassing and non-bypassing instances against a behavioural model.
module tb_regfile_mp_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned AW   = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NWR-1:0]       wr_en;
   logic [NWR*AW-1:0]    wr_addr;
   logic [NWR*XLEN-1:0]  wr_data;
   logic                 rsv_en;
   logic [AW-1:0]        rsv_addr;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data_b, rd_data_n;
   logic [NRD-1:0]       rd_busy_b, rd_busy_n;
   logic [NREG-1:0]      busy_vec_b, busy_vec_n;

   int checks = 0;
   int errors = 0;
   bit mon_on = 1'b0;

   logic [XLEN-1:0] m_regs [NREG];
   bit              m_busy [NREG];

   always #5 clk = ~clk;

   regfile_mp_sb #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .NUM_WR(NWR),
                   .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
      .rd_data(rd_data_b), .rd_busy(rd_busy_b), .busy_vec(busy_vec_b));

   regfile_mp_sb #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .NUM_WR(NWR),
                   .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
      .rd_data(rd_data_n), .rd_busy(rd_busy_n), .busy_vec(busy_vec_n));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state update: ports applied in order so the last one wins, reserve after writes.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         for (int p = 0; p < int'(NWR); p++) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] != 0) begin
               m_regs[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
               m_busy[wr_addr[p*AW +: AW]] = 1'b0;
            end
         end
         if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
   end

   function automatic logic [XLEN-1:0] exp_data(input bit byp, input int r);
      logic [AW-1:0]   a;
      logic [XLEN-1:0] fwd;
      bit              hit;
      a   = rd_addr[r*AW +: AW];
      fwd = '0;
      hit = 1'b0;
      if (rst || a == 0) return '0;
      for (int p = 0; p < int'(NWR); p++) begin
         if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
            hit = 1'b1;
            fwd = wr_data[p*XLEN +: XLEN];
         end
      end
      return (byp && hit) ? fwd : m_regs[a];
   endfunction

   function automatic bit exp_busy(input bit byp, input int r);
      logic [AW-1:0] a;
      bit            hit;
      a   = rd_addr[r*AW +: AW];
      hit = 1'b0;
      if (rst || a == 0) return 1'b0;
      for (int p = 0; p < int'(NWR); p++) begin
         if (wr_en[p] && wr_addr[p*AW +: AW] == a) hit = 1'b1;
      end
      return m_busy[a] && !(byp && hit);
   endfunction

   function automatic logic [NREG-1:0] exp_vec();
      logic [NREG-1:0] v;
      for (int i = 0; i < int'(NREG); i++) v[i] = m_busy[i];
      return v;
   endfunction

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (mon_on) begin
         for (int r = 0; r < int'(NRD); r++) begin
            chk($sformatf("mon_data_byp_r%0d", r), 64'(rd_data_b[r*XLEN +: XLEN]), 64'(exp_data(1'b1, r)));
            chk($sformatf("mon_data_nob_r%0d", r), 64'(rd_data_n[r*XLEN +: XLEN]), 64'(exp_data(1'b0, r)));
            chk($sformatf("mon_busy_byp_r%0d", r), 64'(rd_busy_b[r]), 64'(exp_busy(1'b1, r)));
            chk($sformatf("mon_busy_nob_r%0d", r), 64'(rd_busy_n[r]), 64'(exp_busy(1'b0, r)));
         end
         chk("mon_vec_byp", 64'(busy_vec_b), 64'(exp_vec()));
         chk("mon_vec_nob", 64'(busy_vec_n), 64'(exp_vec()));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = '0;
      rsv_en = 1'b0;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_en[p]                 = 1'b1;
      wr_addr[p*AW +: AW]      = a;
      wr_data[p*XLEN +: XLEN]  = d;
   endtask

   task automatic rsv(input logic [AW-1:0] a);
      rsv_en   = 1'b1;
      rsv_addr = a;
   endtask

   initial begin
      for (int i = 0; i < int'(NREG); i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      rst = 1'b1; idle();
      wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr = '0;
      cyc();
      // reset cycle carrying a write: suppressed and discarded
      wr(0, 5'd5, 32'h1111_1111);
      rd_addr[0 +: AW] = 5'd5;
      #2;
      chk("rst_rd_data", 64'(rd_data_b[31:0]), 64'h0);
      chk("rst_rd_busy", 64'(rd_busy_b), 64'h0);
      cyc();
      rst = 1'b0; idle(); mon_on = 1'b1;
      #2;
      chk("rst_discard_write", 64'(rd_data_b[31:0]), 64'h0);
      chk("rst_busy_vec", 64'(busy_vec_b), 64'h0);

      // write then read back, with and without forwarding
      cyc(); wr(0, 5'd5, 32'hDEAD_BEEF);
      #2;
      chk("wr_cycle_byp", 64'(rd_data_b[31:0]), 64'hDEAD_BEEF);
      chk("wr_cycle_nob", 64'(rd_data_n[31:0]), 64'h0);
      cyc(); idle();
      #2;
      chk("wr_next_byp", 64'(rd_data_b[31:0]), 64'hDEAD_BEEF);
      chk("wr_next_nob", 64'(rd_data_n[31:0]), 64'hDEAD_BEEF);

      // register zero ignores writes and reservations
      cyc(); wr(0, 5'd0, 32'h1234_5678); rsv(5'd0); rd_addr[0 +: AW] = 5'd0;
      #2;
      chk("zero_rd_data", 64'(rd_data_b[31:0]), 64'h0);
      chk("zero_rd_busy", 64'(rd_busy_b[0]), 64'h0);
      cyc(); idle();
      #2;
      chk("zero_after_data", 64'(rd_data_b[31:0]), 64'h0);
      chk("zero_after_vec", 64'(busy_vec_b), 64'h0);

      // write collision: highest port wins
      cyc(); wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2); rd_addr[AW +: AW] = 5'd7;
      #2;
      chk("coll_bypass", 64'(rd_data_b[63:32]), 64'h2);
      chk("coll_nob_old", 64'(rd_data_n[63:32]), 64'h0);
      cyc(); idle();
      #2;
      chk("coll_stored_byp", 64'(rd_data_b[63:32]), 64'h2);
      chk("coll_stored_nob", 64'(rd_data_n[63:32]), 64'h2);

      // scoreboard lifecycle on register 10
      cyc(); rsv(5'd10); rd_addr[0 +: AW] = 5'd10;
      #2;
      chk("sb_not_yet_busy", 64'(rd_busy_b[0]), 64'h0);
      cyc(); idle();
      #2;
      chk("sb_vec10_set", 64'(busy_vec_b[10]), 64'h1);
      chk("sb_rd_busy", 64'(rd_busy_b[0]), 64'h1);
      cyc(); wr(1, 5'd10, 32'hAA);
      #2;
      chk("sb_retire_busy_byp", 64'(rd_busy_b[0]), 64'h0);
      chk("sb_retire_data_byp", 64'(rd_data_b[31:0]), 64'hAA);
      chk("sb_retire_busy_nob", 64'(rd_busy_n[0]), 64'h1);
      chk("sb_retire_data_nob", 64'(rd_data_n[31:0]), 64'h0);
      cyc(); idle();
      #2;
      chk("sb_vec10_clear", 64'(busy_vec_b[10]), 64'h0);
      chk("sb_data10", 64'(rd_data_b[31:0]), 64'hAA);

      // reserve and write the same busy register: stays busy, data updates
      cyc(); rsv(5'd3);
      cyc(); idle(); rsv(5'd3); wr(0, 5'd3, 32'h33); rd_addr[0 +: AW] = 5'd3;
      #2;
      chk("rw_same_data", 64'(rd_data_b[31:0]), 64'h33);
      cyc(); idle();
      #2;
      chk("rw_vec3", 64'(busy_vec_b[3]), 64'h1);
      chk("rw_stored", 64'(rd_data_b[31:0]), 64'h33);
      chk("rw_rd_busy", 64'(rd_busy_b[0]), 64'h1);

      // reset while producers are in flight
      cyc(); wr(0, 5'd4, 32'h55); wr(1, 5'd9, 32'h55); rsv(5'd4);
      cyc(); idle(); rsv(5'd9);
      cyc(); idle(); rd_addr[0 +: AW] = 5'd4; rd_addr[AW +: AW] = 5'd9;
      #2;
      chk("mid_vec_before", 64'(busy_vec_b), 64'h218);
      chk("mid_reg4_before", 64'(rd_data_b[31:0]), 64'h55);
      chk("mid_reg9_before", 64'(rd_data_b[63:32]), 64'h55);
      cyc(); rst = 1'b1; wr(0, 5'd4, 32'h77);
      #2;
      chk("mid_rst_data", 64'(rd_data_b[31:0]), 64'h0);
      chk("mid_rst_busy", 64'(rd_busy_b), 64'h0);
      cyc(); rst = 1'b0; idle();
      #2;
      chk("mid_vec_after", 64'(busy_vec_b), 64'h0);
      chk("mid_vec_after_nob", 64'(busy_vec_n), 64'h0);
      chk("mid_reg4_after", 64'(rd_data_b[31:0]), 64'h0);
      chk("mid_reg9_after", 64'(rd_data_b[63:32]), 64'h0);

      // mixed traffic over a narrow address window to provoke collisions
      for (int k = 0; k < 300; k++) begin
         cyc();
         rst      = ($urandom_range(0, 39) == 0);
         wr_en    = NWR'($urandom_range(0, 3));
         wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_data  = {$urandom(), $urandom()};
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = 5'($urandom_range(0, 7));
         rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      end
      cyc(); rst = 1'b0; idle();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
